// File: rtl/credit_rr_if.sv
// Handshake bundle between the upstream FIFO pop logic and credit_rr_arbiter.
// The master side drives requests and credit returns. The slave (arbiter) side drives grants and credit status.
interface credit_rr_if #(
  parameter int NREQ = 4,
  parameter int CWID = 3
);
  logic [NREQ-1:0] req;
  logic            credit_return;
  logic [NREQ-1:0] grant;
  logic            has_credits;
  logic [CWID-1:0] credits;
  logic            credit_err;

  modport master (
    output req, credit_return,
    input  grant, has_credits, credits, credit_err
  );

  modport slave (
    input  req, credit_return,
    output grant, has_credits, credits, credit_err
  );
endinterface

// File: rtl/credit_rr_arbiter.sv
// Round-robin pop arbiter that shares one downstream credit pool among NREQ FIFOs.
// Optional macro CREDIT_BYPASS_EN: a credit returned while stalled can be granted in that same cycle.
module credit_rr_arbiter #(
  parameter int NREQ        = 4,
  parameter int CREDITS_MAX = 4,
  parameter int CWID        = $clog2(CREDITS_MAX + 1)
) (
  input logic       clk,
  input logic       rst,
  credit_rr_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic {RUN, STALL} state_t;

  state_t          state;
  state_t          state_next;
  logic [CWID-1:0] credit_cnt;
  logic            err_q;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_next;
  logic [PW-1:0]   gidx;
  logic [PW:0]     scan;
  logic            found;
  logic            has_credits;
  logic            grant_en;
  logic [NREQ-1:0] grant_vec;
  logic            inc;
  logic            dec;

  // Scan from rr_ptr upward with wrap; the first set request wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    scan  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan >= (PW+1)'(NREQ))
        scan = scan - (PW+1)'(NREQ);
      if (!found && bus.req[scan[PW-1:0]]) begin
        found = 1'b1;
        gidx  = scan[PW-1:0];
      end
    end
  end

`ifdef CREDIT_BYPASS_EN
  assign has_credits = (state == RUN) | bus.credit_return;
`else
  assign has_credits = (state == RUN);
`endif

  assign grant_en = found & has_credits & ~rst;
  assign dec      = grant_en;
  assign inc      = bus.credit_return;
  assign rr_next  = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);

  always_comb begin
    grant_vec = '0;
    if (grant_en)
      grant_vec[gidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= state_next;
  end

  // RUN mirrors a non-zero count; a bypassed grant in STALL nets to zero and stays stalled.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:   if (credit_cnt == CWID'(1) && dec && !inc) state_next = STALL;
      STALL: if (inc && !dec)                           state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= CWID'(CREDITS_MAX);
      err_q      <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      if (grant_en)
        rr_ptr <= rr_next;
      unique case ({inc, dec})
        2'b01:   credit_cnt <= credit_cnt - CWID'(1);
        2'b10: begin
          if (credit_cnt == CWID'(CREDITS_MAX))
            err_q <= 1'b1;
          else
            credit_cnt <= credit_cnt + CWID'(1);
        end
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  assign bus.grant       = grant_vec;
  assign bus.has_credits = has_credits;
  assign bus.credits     = credit_cnt;
  assign bus.credit_err  = err_q;
endmodule

// File: tb/tb_credit_rr_arbiter.sv
// Self-checking bench for credit_rr_arbiter: directed scenarios plus random traffic vs a behavioural model.
// Honours CREDIT_BYPASS_EN in the model so it can be built in either mode.
module tb_credit_rr_arbiter;
  localparam int NREQ = 4;
  localparam int CMAX = 4;
  localparam int CWID = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  credit_rr_if #(.NREQ(NREQ), .CWID(CWID)) bus ();

  credit_rr_arbiter #(.NREQ(NREQ), .CREDITS_MAX(CMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int m_credits;
  int m_rr;
  int m_err;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_credits = CMAX;
    m_rr      = 0;
    m_err     = 0;
  endtask

  // Drive one cycle of inputs, check combinational and registered outputs, then advance the model.
  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] rq, input logic cr);
    int  gi;
    int  exp_grant;
    int  idx;
    bit  has;
    @(negedge clk);
    rst               = r;
    bus.req           = rq;
    bus.credit_return = cr;
    #1;
    has = (m_credits != 0);
`ifdef CREDIT_BYPASS_EN
    has = has || cr;
`endif
    gi = -1;
    if (!r && has) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (gi < 0 && rq[idx]) gi = idx;
      end
    end
    exp_grant = (gi >= 0) ? (1 << gi) : 0;
    checkOutput("grant",       32'(bus.grant),       32'(exp_grant));
    checkOutput("has_credits", 32'(bus.has_credits), 32'(has));
    checkOutput("credits",     32'(bus.credits),     32'(m_credits));
    checkOutput("credit_err",  32'(bus.credit_err),  32'(m_err));
    @(posedge clk);
    if (r) begin
      modelReset();
    end else begin
      if (gi >= 0) m_rr = (gi + 1) % NREQ;
      if (cr && gi < 0) begin
        if (m_credits == CMAX) m_err = 1;
        else m_credits++;
      end else if (!cr && gi >= 0) begin
        m_credits--;
      end
    end
  endtask

  initial begin
    int inflight;
    logic       cr;
    logic       rr;
    logic [3:0] rq;

    rst               = 1'b1;
    bus.req           = '0;
    bus.credit_return = 1'b0;
    repeat (2) @(posedge clk);
    modelReset();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);

    // Drain all credits with every queue requesting: 0001, 0010, 0100, 1000, then stall.
    repeat (5) applyStimulus(1'b0, 4'b1111, 1'b0);
    #1;
    checkOutput("drained_credits", 32'(bus.credits), 32'd0);
    checkOutput("drained_stall",   32'(bus.has_credits), 32'd0);

    // Single credit returned while stalled.
    applyStimulus(1'b0, 4'b0001, 1'b1);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);

    // Refill to 3, move rr_ptr to 2, then exercise the wrap.
    repeat (3) applyStimulus(1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0010, 1'b0);
    applyStimulus(1'b0, 4'b0011, 1'b0);
    applyStimulus(1'b0, 4'b0011, 1'b0);

    // Simultaneous grant and return at credits=2 must not drift.
    repeat (2) applyStimulus(1'b0, 4'b0000, 1'b1);
    repeat (10) applyStimulus(1'b0, 4'b1111, 1'b1);
    #1;
    checkOutput("no_drift_credits", 32'(bus.credits),    32'd2);
    checkOutput("no_drift_err",     32'(bus.credit_err), 32'd0);

    // Overflow sets the sticky error, which survives until reset.
    repeat (2) applyStimulus(1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    repeat (3) applyStimulus(1'b0, 4'b0000, 1'b0);
    #1;
    checkOutput("err_sticky",  32'(bus.credit_err), 32'd1);
    checkOutput("err_credits", 32'(bus.credits),    32'd4);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    #1;
    checkOutput("err_cleared", 32'(bus.credit_err), 32'd0);

    // Reset in the middle of traffic with requests active.
    repeat (3) applyStimulus(1'b0, 4'b1111, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    #1;
    checkOutput("rst_credits", 32'(bus.credits), 32'd4);
    applyStimulus(1'b0, 4'b0110, 1'b0);

    // Random traffic; downstream returns only what is in flight, with rare overflow returns.
    for (int n = 0; n < 600; n++) begin
      inflight = CMAX - m_credits;
      if (inflight > 0) cr = 1'($urandom_range(0, 1));
      else              cr = ($urandom_range(0, 49) == 0);
      rr = ($urandom_range(0, 99) == 0);
      rq = 4'($urandom_range(0, 15));
      applyStimulus(rr, rq, cr);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
